// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync
//
// Input-conditioning stage for the board toggle switches. Every raw switch
// line is brought into the clk domain through a two-flop synchroniser and
// then debounced by its own stability counter. A new level is only accepted
// once the synchronised bit has differed from the published level for
// STABLE_CYCLES consecutive clock edges.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-low reset (0 = reset)
//   sw_raw       raw asynchronous switch levels
//   sw_stable    debounced switch levels (bits 7..0 encoder data, bit 8 enable)
//   sw_changed   one-cycle pulse per bit in the cycle after sw_stable updates
//   any_change   OR of sw_changed, registered alongside it
//   event_count  number of cycles with any_change high, modulo 256
module sw_debounce_sync #(
  parameter int WIDTH         = 9,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change,
  output logic [7:0]       event_count
);

  // Counter value on the edge where the bit is accepted: the bit has then
  // differed on STABLE_CYCLES consecutive evaluations (0 .. STABLE_CYCLES-1).
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             any_q, any_d;
  logic [7:0]       evcnt_q, evcnt_d;

  // Per-bit stability counters. A bit that matches the published level
  // holds its counter at zero, so any glitch back to the old level restarts
  // the qualification window.
  always_comb begin
    stable_d  = stable_q;
    changed_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        stable_d[i]  = s2_q[i];
        changed_d[i] = 1'b1;
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    any_d = |changed_d;
    // Counts cycles with an accepted change, not the number of bits changed.
    evcnt_d = evcnt_q + {7'd0, any_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      changed_q <= '0;
      any_q     <= 1'b0;
      evcnt_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= sw_raw;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      any_q     <= any_d;
      evcnt_q   <= evcnt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable   = stable_q;
  assign sw_changed  = changed_q;
  assign any_change  = any_q;
  assign event_count = evcnt_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
module tb_sw_debounce_sync;

  localparam int W  = 9;
  localparam int SC = 4;
  localparam int CW = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_changed;
  logic         any_change;
  logic [7:0]   event_count;

  int n_total;
  int n_pass;

  sw_debounce_sync #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .any_change (any_change),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each evaluation sees the raw level from two edges earlier. A bit is
  // accepted when the last SC observations since its previous acceptance
  // all disagree with the published level.
  logic [W-1:0]  m_stable, m_changed;
  logic          m_any;
  logic [7:0]    m_evcnt;
  logic [W-1:0]  p0, p1, syn;
  logic [SC-1:0] win [W];
  int            fill [W];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_stable = '0; m_changed = '0; m_any = 1'b0; m_evcnt = '0;
      p0 = '0; p1 = '0;
      for (int i = 0; i < W; i++) begin win[i] = '0; fill[i] = 0; end
    end else begin
      m_evcnt = m_evcnt + (m_any ? 8'd1 : 8'd0);
      syn = p1; p1 = p0; p0 = sw_raw;
      m_changed = '0;
      for (int i = 0; i < W; i++) begin
        win[i] = {win[i][SC-2:0], syn[i]};
        if (fill[i] < SC) fill[i] = fill[i] + 1;
        if (fill[i] == SC && win[i] == (m_stable[i] ? {SC{1'b0}} : {SC{1'b1}})) begin
          m_stable[i]  = ~m_stable[i];
          m_changed[i] = 1'b1;
          fill[i]      = 0;
        end
      end
      m_any = |m_changed;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("stable_vs_model",  32'(sw_stable),   32'(m_stable));
    chk("changed_vs_model", 32'(sw_changed),  32'(m_changed));
    chk("any_vs_model",     32'(any_change),  32'(m_any));
    chk("evcnt_vs_model",   32'(event_count), 32'(m_evcnt));
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    @(negedge clk);
    rst = 1'b0; sw_raw = raw;
    ticks(3);
    rst = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_total = 0; n_pass = 0;
    rst = 1'b1; sw_raw = '0;

    // Reset with all switches high, then release.
    do_reset(9'h1FF);
    rst = 1'b0;
    ticks(1);
    chk("rst_stable",  32'(sw_stable),   32'h0);
    chk("rst_changed", 32'(sw_changed),  32'h0);
    chk("rst_any",     32'(any_change),  32'h0);
    chk("rst_evcnt",   32'(event_count), 32'h0);
    rst = 1'b1;
    ticks(5);
    chk("rel_stable_e5", 32'(sw_stable), 32'h000);
    ticks(1);
    chk("rel_stable_e6",  32'(sw_stable),  32'h1FF);
    chk("rel_changed_e6", 32'(sw_changed), 32'h1FF);
    ticks(1);
    chk("rel_changed_e7", 32'(sw_changed),  32'h000);
    chk("rel_evcnt_e7",   32'(event_count), 32'd1);

    // Single bit from all-zero stable.
    do_reset(9'h000);
    ticks(8);
    sw_raw = 9'h008;
    ticks(5);
    chk("b3_stable_e5", 32'(sw_stable), 32'h000);
    ticks(1);
    chk("b3_stable_e6",  32'(sw_stable),  32'h008);
    chk("b3_changed_e6", 32'(sw_changed), 32'h008);
    chk("b3_any_e6",     32'(any_change), 32'h1);
    ticks(1);
    chk("b3_any_e7",   32'(any_change),  32'h0);
    chk("b3_evcnt_e7", 32'(event_count), 32'd1);

    // Bounce on bit 0: 1 for 3, 0 for 1, then held high.
    sw_raw[0] = 1'b1; ticks(3);
    sw_raw[0] = 1'b0; ticks(1);
    sw_raw[0] = 1'b1;
    ticks(5);
    chk("bounce_e5", 32'(sw_stable), 32'h008);
    ticks(1);
    chk("bounce_e6", 32'(sw_stable), 32'h009);
    ticks(2);
    chk("bounce_evcnt", 32'(event_count), 32'd2);

    // Two bits rising together.
    sw_raw = 9'h189;
    ticks(6);
    chk("simul_changed", 32'(sw_changed), 32'h180);
    ticks(2);
    chk("simul_evcnt", 32'(event_count), 32'd3);

    // Raw level reverts one cycle before acceptance edge; accepted anyway.
    sw_raw[2] = 1'b1; ticks(5);
    sw_raw[2] = 1'b0; ticks(1);
    chk("revert_accept", 32'(sw_stable), 32'h18D);
    ticks(4);
    chk("revert_e10", 32'(sw_stable), 32'h18D);
    ticks(1);
    chk("revert_e11", 32'(sw_stable), 32'h189);
    ticks(2);

    // Reset mid-count on bit 5.
    sw_raw[5] = 1'b1; ticks(3);
    rst = 1'b0; ticks(2);
    chk("midrst_stable", 32'(sw_stable), 32'h000);
    rst = 1'b1;
    ticks(5);
    chk("midrst_e5", 32'(sw_stable), 32'h000);
    ticks(1);
    chk("midrst_e6", 32'(sw_stable), 32'h1A9);

    // event_count wrap.
    do_reset(9'h000);
    ticks(8);
    chk("wrap_start", 32'(event_count), 32'd0);
    for (int k = 1; k <= 257; k++) begin
      sw_raw[1] = ~sw_raw[1];
      ticks(8);
      if (k == 255) chk("wrap_255", 32'(event_count), 32'd255);
      if (k == 256) chk("wrap_256", 32'(event_count), 32'd0);
      if (k == 257) chk("wrap_257", 32'(event_count), 32'd1);
    end

    ticks(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sw_debounce_sync.md
# sw_debounce_sync

Input-conditioning stage between the board toggle switches and the priority-encoder/display path. It synchronises every raw switch line into the `clk` domain and debounces it with a per-bit stability counter. It publishes clean switch levels: bits 7..0 feed the encoder data input and bit 8 feeds its enable. It also emits per-bit change pulses and a wrapping count of accepted change events for display or debug.

## Interface

Parameters:
- `WIDTH` — default 9 — number of switch lines (sw8..sw0).
- `STABLE_CYCLES` — default 50000 — consecutive cycles a synchronised bit must differ from its stable value before being accepted; legal range 2..2^CNT_W-1.
- `CNT_W` — default 16 — width of each per-bit stability counter.

Ports:
- `clk` input 1 — single clock; all state on its rising edge.
- `rst` input 1 — reset, asynchronous assert, active-low (0 = reset); this polarity and synchronicity are fixed.
- `sw_raw` input WIDTH — raw asynchronous switch levels.
- `sw_stable` output WIDTH — debounced levels; bit i meaningful only after acceptance.
- `sw_changed` output WIDTH — one-cycle pulse on bit i in the cycle after `sw_stable[i]` updates.
- `any_change` output 1 — OR of `sw_changed`, registered alongside it.
- `event_count` output 8 — count of cycles in which `any_change` was 1, modulo 256.

## Operation

- Per bit i: two-flop synchroniser `s1[i]` <- `sw_raw[i]`, `s2[i]` <- `s1[i]`. Only `s2` is used downstream.
- Per bit i, counter `cnt[i]` (CNT_W bits), evaluated at every edge:
  - `s2[i] == sw_stable[i]`: `cnt[i]` <- 0; no change.
  - `s2[i] != sw_stable[i]` and `cnt[i] == STABLE_CYCLES-1`: `sw_stable[i]` <- `s2[i]`; `cnt[i]` <- 0; `sw_changed[i]` <- 1.
  - `s2[i] != sw_stable[i]` otherwise: `cnt[i]` <- `cnt[i]+1`.
- `sw_changed[i]` is 0 in every cycle not covered by the acceptance rule, so pulses are exactly one cycle wide.
- Any glitch returning `s2[i]` to the stable value clears `cnt[i]`. Acceptance requires STABLE_CYCLES consecutive differing evaluations.
- Bits are fully independent. Simultaneous acceptance on several bits is legal: multiple `sw_changed` bits may be high together.
- `any_change` <- |(next `sw_changed`), so it is aligned with `sw_changed`.
- `event_count` increments by exactly 1 per cycle where `any_change` = 1, regardless of how many bits changed. It wraps 255 -> 0 with no saturation and no flag.
- No per-bit state machine beyond the counter compare. Counter arithmetic is unsigned CNT_W.

## Timing

- Reset (`rst` = 0, immediate, independent of `clk`): `s1`, `s2`, `sw_stable`, `sw_changed`, and `cnt` all go to 0; `any_change` = 0; `event_count` = 0.
- Reset release: first active evaluation at the first rising edge with `rst` = 1. A switch already high at release is accepted like any other change, with one `sw_changed` pulse and `event_count` = 1.
- Latency: `sw_raw[i]` changes before edge 1 and is held. Then `s1` updates at edge 1 and `s2` at edge 2. `cnt` reaches STABLE_CYCLES-1 at edge STABLE_CYCLES+1. `sw_stable[i]` and `sw_changed[i]` update at edge STABLE_CYCLES+2. Total latency: STABLE_CYCLES+2 cycles.
- `event_count` updates one edge after `any_change` is seen high, i.e. at edge STABLE_CYCLES+3.
- Reset asserted mid-count discards all partial counts. After release, counting restarts from 0 against `sw_stable` = 0.
- A raw level that reverts within 1 cycle of acceptance does not cancel the accepted edge. The revert itself must then satisfy the full STABLE_CYCLES rule.

## Test plan

(All scenarios use STABLE_CYCLES=4, CNT_W=4, WIDTH=9.)

- Reset with `sw_raw`=9'h1FF, rst=0 -> all outputs 0 while low. Release -> `sw_stable`=9'h1FF at 6th edge, `sw_changed`=9'h1FF for 1 cycle, `event_count`=1.
- From all-0 stable, set `sw_raw[3]`=1 held -> `sw_stable`=9'h008 exactly 6 cycles later, `sw_changed`=9'h008 one cycle, `any_change` one cycle, `event_count`=1.
- Bounce: `sw_raw[0]` 1 for 3 cycles, 0 for 1, 1 held -> no acceptance until 6 cycles after final rise; exactly one `sw_changed[0]` pulse.
- Simultaneous: `sw_raw` 9'h000 -> 9'h180 in one cycle -> both bits accept on the same edge, `sw_changed`=9'h180, `event_count` increments by 1 only.
- Reset mid-count: raise `sw_raw[5]`, assert rst after 3 cycles, release -> `sw_stable[5]` accepted 6 cycles after release, never earlier.
- Wrap: 256 accepted toggles of `sw_raw[1]` -> `event_count` returns to 0; 257th -> 1.
